sound_resampler: RTL and testbench

Box-filter decimator feeding the I2S/left-justified `SoundDriver` stage. It integrates two held 16-bit unsigned audio levels (left/right APU mix) on every `CLK` over a fixed 768-cycle frame, which is one `SoundDriver` LRCK frame at 24 MHz (16 × 48). It scales each integral to a 16-bit average, converts it to two's complement, and delivers one left and one right word per frame on the driver's `write_data`/`write_left`/`write_right` port.

---
 rtl/sound_resampler.sv | 140 ++++++++++++++
 tb/tb_sound_resampler.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/sound_resampler.sv
// sound_resampler: box-filter decimator for the SoundDriver stage.
// Integrates two 16-bit unsigned levels over a 768-cycle frame, scales each
// integral to a 16-bit average with one shared multiplier, converts to two's
// complement and emits a left word then a right word once per frame.
module sound_resampler #(
    parameter int unsigned PERIOD = 768,
    parameter logic [15:0] SCALE  = 16'd21845
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic [15:0] in_l,
    input  logic [15:0] in_r,
    input  logic        mute,
    output logic [15:0] write_data,
    output logic        write_left,
    output logic        write_right,
    output logic        frame
);

    typedef enum logic [2:0] {
        ST_ACC,
        ST_ML,
        ST_WL,
        ST_MR,
        ST_WR
    } state_t;

    localparam logic [9:0] LP_LAST = 10'(PERIOD - 1);
    localparam logic [9:0] LP_PRE  = 10'(PERIOD - 2);

    state_t      r_state;
    state_t      w_state_nxt;
    logic [9:0]  r_cnt;
    logic [25:0] r_acc_l;
    logic [25:0] r_acc_r;
    logic [25:0] r_hold_l;
    logic [25:0] r_hold_r;
    logic [15:0] r_write_data;
    logic        r_write_left;
    logic        r_write_right;
    logic        r_frame;

    logic        w_wrap;
    logic [25:0] w_sum_l;
    logic [25:0] w_sum_r;
    logic [17:0] w_mul_a;
    logic [33:0] w_product;
    logic [15:0] w_avg;
    logic [15:0] w_word;
    logic        w_unused_bits;

    // Wrap decode and running sums that include the current sample.
    assign w_wrap  = (r_cnt == LP_LAST);
    assign w_sum_l = r_acc_l + 26'(in_l);
    assign w_sum_r = r_acc_r + 26'(in_r);

    // Shared multiplier: right channel only while in MR, left otherwise.
    assign w_mul_a   = (r_state == ST_MR) ? r_hold_r[25:8] : r_hold_l[25:8];
    assign w_product = 34'(w_mul_a) * 34'(SCALE);
    assign w_avg     = w_product[31:16];
    assign w_word    = mute ? 16'h0000 : (w_avg ^ 16'h8000);

    // Bits dropped by the >>8 and >>16 truncations; the product never
    // reaches bits 33:32 because the average is at most 65534.
    assign w_unused_bits = &{1'b0, w_product[33:32], w_product[15:0],
                             r_hold_l[7:0], r_hold_r[7:0]};

    // Frame counter, integrators and wrap-cycle capture into the hold registers.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_cnt    <= '0;
            r_acc_l  <= '0;
            r_acc_r  <= '0;
            r_hold_l <= '0;
            r_hold_r <= '0;
            r_frame  <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register here samples
            // the pre-edge values; blocking would chain acc into hold.
            r_frame <= (r_cnt == LP_PRE);
            if (w_wrap) begin
                r_cnt    <= '0;
                r_hold_l <= w_sum_l;
                r_hold_r <= w_sum_r;
                r_acc_l  <= '0;
                r_acc_r  <= '0;
            end else begin
                r_cnt   <= r_cnt + 10'd1;
                r_acc_l <= w_sum_l;
                r_acc_r <= w_sum_r;
            end
        end
    end

    // FSM state register.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_state <= ST_ACC;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM next state: one pass ACC -> ML -> WL -> MR -> WR per frame wrap.
    always_comb begin
        // NOTE: default assigned first so no path through the case leaves
        // the signal unassigned, which would infer a latch.
        w_state_nxt = r_state;
        case (r_state)
            ST_ACC:  if (w_wrap) w_state_nxt = ST_ML;
            ST_ML:   w_state_nxt = ST_WL;
            ST_WL:   w_state_nxt = ST_MR;
            ST_MR:   w_state_nxt = ST_WR;
            ST_WR:   w_state_nxt = ST_ACC;
            default: w_state_nxt = ST_ACC;
        endcase
    end

    // Output register: the word is captured at the end of ML/MR so the
    // strobe and data are visible together during WL/WR.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_write_data  <= '0;
            r_write_left  <= 1'b0;
            r_write_right <= 1'b0;
        end else begin
            r_write_left  <= (r_state == ST_ML);
            r_write_right <= (r_state == ST_MR);
            if ((r_state == ST_ML) || (r_state == ST_MR)) begin
                r_write_data <= w_word;
            end
        end
    end

    assign write_data  = r_write_data;
    assign write_left  = r_write_left;
    assign write_right = r_write_right;
    assign frame       = r_frame;

endmodule

// File: tb/tb_sound_resampler.sv
// Directed bench for sound_resampler: strobe timing, averaging, mute,
// mid-frame reset and 20 frames of random input against a reference model.
module tb_sound_resampler;

    logic        CLK = 1'b0;
    logic        RST_N;
    logic [15:0] in_l;
    logic [15:0] in_r;
    logic        mute;
    logic [15:0] write_data;
    logic        write_left;
    logic        write_right;
    logic        frame;

    int n_assert = 0;
    int n_fail   = 0;
    bit overlap_seen = 1'b0;

    sound_resampler dut (
        .CLK         (CLK),
        .RST_N       (RST_N),
        .in_l        (in_l),
        .in_r        (in_r),
        .mute        (mute),
        .write_data  (write_data),
        .write_left  (write_left),
        .write_right (write_right),
        .frame       (frame)
    );

    always #5 CLK = ~CLK;

    // Strobes must never be high together.
    always @(negedge CLK) begin
        if (write_left && write_right) overlap_seen = 1'b1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance n rising edges, then settle 1 time unit past the edge.
    task automatic advance(input int n);
        repeat (n) begin
            @(posedge CLK);
            #1;
        end
    endtask

    // Reference: ((sum >> 8) * 21845 >> 16) ^ 0x8000.
    function automatic logic [15:0] model(input longint unsigned s);
        longint unsigned p;
        logic [15:0]     avg;
        p   = (s >> 8) * 64'd21845;
        avg = 16'(p >> 16);
        return avg ^ 16'h8000;
    endfunction

    // Entered at frame cycle 0 (the ML cycle of the previous wrap).
    // Applies constant inputs for this frame, checks the previous frame's
    // strobes at cycles 1 and 3, checks frame at cycle 767, exits at the
    // next frame's cycle 0. With half set, in_l drops to 0 from cycle 384.
    task automatic run_frame(input logic [15:0] l, input logic [15:0] r, input logic m,
                             input bit chk, input logic [15:0] el, input logic [15:0] er,
                             input bit half, input string tag);
        in_l = l;
        in_r = r;
        mute = m;
        check({tag, "_c0_strobes"}, {write_left, write_right}, 2'b00);
        advance(1);
        check({tag, "_wl"}, {write_left, write_right}, {chk, 1'b0});
        if (chk) check({tag, "_left_word"}, write_data, el);
        advance(1);
        check({tag, "_c2_strobes"}, {write_left, write_right}, 2'b00);
        advance(1);
        check({tag, "_wr"}, {write_left, write_right}, {1'b0, chk});
        if (chk) check({tag, "_right_word"}, write_data, er);
        advance(1);
        if (chk) check({tag, "_data_hold"}, write_data, er);
        if (half) begin
            advance(380);
            in_l = 16'h0000;
            advance(383);
        end else begin
            advance(763);
        end
        check({tag, "_frame"}, frame, 1'b1);
        advance(1);
    endtask

    initial begin
        logic [15:0]     exp_l;
        logic [15:0]     exp_r;
        longint unsigned sum_l;
        longint unsigned sum_r;

        RST_N = 1'b0;
        in_l  = 16'h0000;
        in_r  = 16'h0000;
        mute  = 1'b0;
        #1;
        check("reset_outputs", {write_data, write_left, write_right, frame}, 19'h0);
        advance(2);
        check("reset_outputs_clocked", {write_data, write_left, write_right, frame}, 19'h0);

        // Release mid-cycle; the next rising edge closes cycle 0.
        @(negedge CLK);
        RST_N = 1'b1;

        // Full-scale: first strobes at cycles 769 / 771, word 0x7FFE.
        run_frame(16'hFFFF, 16'hFFFF, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0, "f0");
        // Midscale left, zero right.
        run_frame(16'h8000, 16'h0000, 1'b0, 1'b1, 16'h7FFE, 16'h7FFE, 1'b0, "f1");
        // Half frame at full scale on the left (sum 25165440 -> avg 32766).
        run_frame(16'hFFFF, 16'h8000, 1'b0, 1'b1, 16'hFFFF, 16'h8000, 1'b1, "f2");
        run_frame(16'hFFFF, 16'hFFFF, 1'b0, 1'b1, 16'hFFFE, 16'hFFFF, 1'b0, "f3");
        // Mute while the full-scale frame's words are registered.
        run_frame(16'hFFFF, 16'h8000, 1'b1, 1'b1, 16'h0000, 16'h0000, 1'b0, "f4_mute");
        run_frame(16'h1234, 16'hABCD, 1'b0, 1'b1, 16'h7FFE, 16'hFFFF, 1'b0, "f5");

        // Reset during MR (wrap + 3): left of frame f5 appears, right must not.
        in_l = 16'hFFFF;
        in_r = 16'hFFFF;
        advance(1);
        check("rst_pre_wl", {write_left, write_right}, 2'b10);
        check("rst_pre_left_word", write_data, 16'h9233);
        advance(1);
        RST_N = 1'b0;
        #1;
        check("rst_outputs_now", {write_data, write_left, write_right, frame}, 19'h0);
        advance(3);
        check("rst_outputs_held", {write_data, write_left, write_right, frame}, 19'h0);
        @(negedge CLK);
        RST_N = 1'b1;

        // Post-reset timing matches the first release: no strobes in the
        // first frame, next strobes at the same offsets as after power-up.
        run_frame(16'hFFFF, 16'hFFFF, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0, "post_rst");

        // Random inputs every cycle for 20 frames.
        exp_l = 16'h7FFE;
        exp_r = 16'h7FFE;
        for (int f = 0; f <= 20; f++) begin
            sum_l = 0;
            sum_r = 0;
            for (int c = 0; c < 768; c++) begin
                if (f < 20) begin
                    in_l = 16'($urandom);
                    in_r = 16'($urandom);
                end else begin
                    in_l = 16'h0000;
                    in_r = 16'h0000;
                end
                sum_l += longint'(in_l);
                sum_r += longint'(in_r);
                if (c == 1) begin
                    check($sformatf("rnd%0d_wl", f), {write_left, write_right}, 2'b10);
                    check($sformatf("rnd%0d_left_word", f), write_data, exp_l);
                end
                if (c == 3) begin
                    check($sformatf("rnd%0d_wr", f), {write_left, write_right}, 2'b01);
                    check($sformatf("rnd%0d_right_word", f), write_data, exp_r);
                end
                if ((f == 20) && (c == 4)) break;
                advance(1);
            end
            exp_l = model(sum_l);
            exp_r = model(sum_r);
        end

        check("no_strobe_overlap", overlap_seen, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
